stage2_booth_accum: RTL and testbench

STAGE2_BOOTH_ACCUM -- requirements
Module: stage2_booth_accum

---
 rtl/stage2_booth_accum.sv | 160 ++++++++++++++++
 tb/tb_stage2_booth_accum.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage2_booth_accum.sv
// Multiplier stage 2: radix-4 Booth multiply of two signed DATA_WIDTH/2-bit
// operands into a signed DATA_WIDTH-bit product, using one partial product per cycle.
//
// Ports:
//   lt            stage clock; every state update happens on its rising edge
//   rst_n         asynchronous, active-low reset
//   in_valid      upstream operand pair valid
//   in_ready      high in IDLE from the first edge after reset
//   multiplicand  operand A, two's complement, DATA_WIDTH/2 bits
//   multiplier    operand B, two's complement, DATA_WIDTH/2 bits
//   out_valid     product valid, high in DONE
//   out_ready     stage3 has latched the product
//   product       signed A*B, held until the next result is produced
//   busy          high in CALC and DONE
//
// Optional build macro: STAGE2_ZERO_SKIP_EN. When it is defined, an operand
// pair containing a zero finishes on the first CALC edge with product 0.
module stage2_booth_accum #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    lt,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH/2-1:0] multiplicand,
    input  logic [DATA_WIDTH/2-1:0] multiplier,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   product,
    output logic                    busy
);

    localparam int HW    = DATA_WIDTH / 2;
    localparam int ITERS = DATA_WIDTH / 4;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  live_q;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [HW-1:0]         b_q, b_d;
    logic                  bm1_q, bm1_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] prod_q, prod_d;
    logic                  skip_q, skip_d;

    logic                  zero_in;
    logic [2:0]            trip;
    logic [DATA_WIDTH-1:0] pp;
    logic [DATA_WIDTH-1:0] sum;

`ifdef STAGE2_ZERO_SKIP_EN
    assign zero_in = (multiplicand == '0) || (multiplier == '0);
`else
    assign zero_in = 1'b0;
`endif

    // a_q holds A sign-extended and already shifted by 2i, and b_q is B
    // shifted right by 2i, so the triplet always sits in the low bits and
    // no variable shifter is needed.
    assign trip = {b_q[1], b_q[0], bm1_q};

    always_comb begin
        pp = '0;
        unique case (trip)
            3'b000, 3'b111: pp = '0;
            3'b001, 3'b010: pp = a_q;
            3'b011:         pp = a_q << 1;
            3'b100:         pp = -(a_q << 1);
            3'b101, 3'b110: pp = -a_q;
        endcase
    end

    assign sum = acc_q + pp;

    // live_q keeps in_ready low until the first clock edge after reset.
    assign in_ready  = live_q && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = prod_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        bm1_d   = bm1_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        skip_d  = skip_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = {{HW{multiplicand[HW-1]}}, multiplicand};
                    b_d     = multiplier;
                    bm1_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    skip_d  = zero_in;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (skip_q) begin
                    prod_d  = '0;
                    state_d = DONE;
                end else begin
                    acc_d = sum;
                    a_d   = a_q << 2;
                    b_d   = b_q >> 2;
                    bm1_d = b_q[1];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        prod_d  = sum;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge lt or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            bm1_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            a_q     <= a_d;
            b_q     <= b_d;
            bm1_q   <= bm1_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            skip_q  <= skip_d;
        end
    end

endmodule

// File: tb/tb_stage2_booth_accum.sv
// Bench for stage2_booth_accum: directed steps plus randomized back-to-back
// operations compared against plain signed multiplication.
module tb_stage2_booth_accum;

    localparam int DW    = 16;
    localparam int HW    = DW / 2;
    localparam int ITERS = DW / 4;
`ifdef STAGE2_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = ITERS;
`endif

    logic          lt;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [HW-1:0] mcand;
    logic [HW-1:0] mplier;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] product;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    stage2_booth_accum #(.DATA_WIDTH(DW)) dut (
        .lt           (lt),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    initial lt = 1'b0;
    always #5 lt = ~lt;
    always @(posedge lt) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] ref_prod(input logic [HW-1:0] a,
                                             input logic [HW-1:0] b);
        int ia;
        int ib;
        int p;
        ia = $signed(a);
        ib = $signed(b);
        p  = ia * ib;
        return {16'h0, p[15:0]};
    endfunction

    function automatic int ref_lat(input logic [HW-1:0] a,
                                   input logic [HW-1:0] b);
        if (a == '0 || b == '0) return ZLAT;
        return ITERS;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge in IDLE; returns at the negedge where out_valid
    // is first seen (or the wait bound expired).
    task automatic run_op(input string tag, input logic [HW-1:0] a,
                          input logic [HW-1:0] b);
        int n;
        chk({tag, "_rdy"}, {31'h0, in_ready}, 32'd1);
        mcand    = a;
        mplier   = b;
        in_valid = 1'b1;
        @(negedge lt);
        in_valid = 1'b0;
        mcand    = HW'($urandom);
        mplier   = HW'($urandom);
        chk({tag, "_busy"}, {30'h0, busy, in_ready}, 32'd2);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge lt);
            n++;
        end
        chk({tag, "_lat"}, n, ref_lat(a, b));
        chk({tag, "_prod"}, {16'h0, product}, ref_prod(a, b));
    endtask

    task automatic finish_op(input string tag, input logic [31:0] exp);
        out_ready = 1'b1;
        @(negedge lt);
        out_ready = 1'b0;
        chk({tag, "_drop"}, {30'h0, out_valid, in_ready}, 32'd1);
        chk({tag, "_hold"}, {16'h0, product}, exp);
    endtask

    logic [HW-1:0] ca [8];
    logic [HW-1:0] cb [8];

    initial begin
        int n;
        int seen;
        int t_acc;
        int prev_acc;
        int prev_lat;
        logic [HW-1:0] a;
        logic [HW-1:0] b;
        logic [DW-1:0] held;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mcand     = '0;
        mplier    = '0;
        #1 rst_n  = 1'b0;
        #1;
        chk("rst_outs", {27'h0, in_ready, out_valid, busy, 1'b0, 1'b0}, 32'd0);
        chk("rst_prod", {16'h0, product}, 32'd0);
        repeat (2) @(negedge lt);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy_pre_edge", {31'h0, in_ready}, 32'd0);
        @(negedge lt);
        chk("rst_rdy_post_edge", {31'h0, in_ready}, 32'd1);

        run_op("a3b5", 8'd3, 8'd5);
        chk("a3b5_val", {16'h0, product}, 32'h000F);
        finish_op("a3b5", 32'h000F);

        run_op("m128sq", 8'h80, 8'h80);
        chk("m128sq_val", {16'h0, product}, 32'h4000);
        finish_op("m128sq", 32'h4000);
        run_op("m1x127", 8'hFF, 8'd127);
        chk("m1x127_val", {16'h0, product}, 32'hFF81);
        finish_op("m1x127", 32'hFF81);
        run_op("127xm128", 8'd127, 8'h80);
        chk("127xm128_val", {16'h0, product}, 32'hC080);
        finish_op("127xm128", 32'hC080);

        // Stall in DONE with noise on the input side.
        run_op("stall", 8'hF9, 8'd9);
        held = 16'hFFC1;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            mcand    = HW'($urandom);
            mplier   = HW'($urandom);
            @(negedge lt);
            chk("stall_state", {29'h0, out_valid, in_ready, busy}, 32'd5);
            chk("stall_prod", {16'h0, product}, {16'h0, held});
        end
        in_valid = 1'b0;
        finish_op("stall", {16'h0, held});

        // out_ready in IDLE has no effect.
        out_ready = 1'b1;
        repeat (3) @(negedge lt);
        out_ready = 1'b0;
        chk("idle_ordy", {29'h0, out_valid, in_ready, busy}, 32'd2);
        chk("idle_prod", {16'h0, product}, {16'h0, held});

        // Reset between CALC iterations 1 and 2.
        mcand    = 8'd50;
        mplier   = 8'h9C;
        in_valid = 1'b1;
        @(negedge lt);
        in_valid = 1'b0;
        repeat (2) @(negedge lt);
        chk("abort_pre", {31'h0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", {29'h0, in_ready, out_valid, busy}, 32'd0);
        chk("abort_prod", {16'h0, product}, 32'd0);
        @(negedge lt);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge lt);
            if (out_valid) seen++;
        end
        chk("abort_stale", seen, 32'd0);
        run_op("a2bm3", 8'd2, 8'hFD);
        chk("a2bm3_val", {16'h0, product}, 32'hFFFA);
        finish_op("a2bm3", 32'hFFFA);

        run_op("a0b77", 8'd0, 8'd77);
        finish_op("a0b77", 32'h0000);

        // Back-to-back with out_ready tied high.
        ca = '{8'h80, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h55};
        cb = '{8'h7F, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'hFF, 8'hAA};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        prev_acc  = 0;
        prev_lat  = 0;
        for (int k = 0; k < 400; k++) begin
            if (k < 8) begin
                a = ca[k];
                b = cb[k];
            end else begin
                a = HW'($urandom);
                b = HW'($urandom);
            end
            n = 0;
            while (!in_ready && n < 20) begin
                @(negedge lt);
                n++;
            end
            if (n >= 20) chk("b2b_rdy_timeout", {31'h0, in_ready}, 32'd1);
            mcand  = a;
            mplier = b;
            t_acc  = cyc;
            if (k > 0) chk("b2b_spacing", t_acc - prev_acc, prev_lat + 2);
            @(negedge lt);
            mcand  = HW'($urandom);
            mplier = HW'($urandom);
            n = 0;
            while (!out_valid && n < 40) begin
                @(negedge lt);
                n++;
            end
            chk("b2b_lat", n, ref_lat(a, b));
            chk("b2b_prod", {16'h0, product}, ref_prod(a, b));
            prev_acc = t_acc;
            prev_lat = ref_lat(a, b);
            @(negedge lt);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge lt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
